// File: rtl/bram_access_arbiter.sv
// Shares one BRAM port between CPU, DMA and prefetch using CPU>DMA>PF priority with aging.
// Has a registered issue stage and a tag pipeline that routes each read return to its owner.
module bram_access_arbiter #(
  parameter int RD_LATENCY   = 10,
  parameter int STARVE_LIMIT = 8,
  parameter int AGE_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_stb,
  input  logic        i_cpu_we,
  input  logic [12:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [31:0] o_cpu_rdata,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [12:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  output logic        o_dma_gnt,
  output logic        o_dma_rvalid,
  output logic [31:0] o_dma_rdata,
  input  logic        i_pf_req,
  input  logic [12:0] i_pf_addr,
  output logic        o_pf_gnt,
  output logic        o_pf_rvalid,
  output logic [31:0] o_pf_rdata,
  output logic        o_brc_in_valid,
  output logic        o_brc_wr,
  output logic [12:0] o_brc_addr,
  output logic [31:0] o_brc_di,
  output logic [1:0]  o_brc_reader_sel,
  input  logic [31:0] i_brc_do
);
  localparam logic [1:0]       SEL_DMA = 2'b00;
  localparam logic [1:0]       SEL_CPU = 2'b01;
  localparam logic [1:0]       SEL_PF  = 2'b10;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic                       r_cpu_busy;
  logic                       r_cpu_wack;
  logic [AGE_W-1:0]           r_age_cpu, r_age_dma, r_age_pf;
  logic                       r_brc_in_valid, r_brc_wr;
  logic [12:0]                r_brc_addr;
  logic [31:0]                r_brc_di;
  logic [1:0]                 r_brc_sel;
  logic [RD_LATENCY-1:0]      r_tag_vld;
  logic [RD_LATENCY-1:0][1:0] r_tag_sel;

  logic       w_elig_cpu, w_elig_dma, w_elig_pf;
  logic       w_gnt_cpu, w_gnt_dma, w_gnt_pf;
  logic       w_issue_rd, w_ret_vld;
  logic [1:0] w_ret_sel;

  function automatic logic [AGE_W-1:0] next_age(input logic elig, input logic gnt,
                                                input logic [AGE_W-1:0] age);
    if (!elig || gnt) return '0;
    if (age == AGE_MAX) return age;
    return age + 1'b1;
  endfunction

  // Grants are suppressed during reset so no request is accepted and then dropped.
  always_comb begin
    w_elig_cpu = i_cpu_stb & ~r_cpu_busy & ~i_rst;
    w_elig_dma = i_dma_req & ~i_rst;
    w_elig_pf  = i_pf_req & ~i_rst;
    w_gnt_cpu  = 1'b0;
    w_gnt_dma  = 1'b0;
    w_gnt_pf   = 1'b0;
    if (w_elig_cpu && r_age_cpu == AGE_MAX)      w_gnt_cpu = 1'b1;
    else if (w_elig_dma && r_age_dma == AGE_MAX) w_gnt_dma = 1'b1;
    else if (w_elig_pf && r_age_pf == AGE_MAX)   w_gnt_pf  = 1'b1;
    else if (w_elig_cpu)                         w_gnt_cpu = 1'b1;
    else if (w_elig_dma)                         w_gnt_dma = 1'b1;
    else if (w_elig_pf)                          w_gnt_pf  = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_brc_in_valid <= 1'b0;
      r_brc_wr       <= 1'b0;
      r_brc_addr     <= '0;
      r_brc_di       <= '0;
      r_brc_sel      <= '0;
    end else begin
      r_brc_in_valid <= w_gnt_cpu | w_gnt_dma | w_gnt_pf;
      r_brc_wr       <= 1'b0;
      r_brc_addr     <= '0;
      r_brc_di       <= '0;
      r_brc_sel      <= '0;
      if (w_gnt_cpu) begin
        r_brc_wr   <= i_cpu_we;
        r_brc_addr <= i_cpu_addr;
        r_brc_di   <= i_cpu_wdata;
        r_brc_sel  <= SEL_CPU;
      end else if (w_gnt_dma) begin
        r_brc_wr   <= i_dma_we;
        r_brc_addr <= i_dma_addr;
        r_brc_di   <= i_dma_wdata;
        r_brc_sel  <= SEL_DMA;
      end else if (w_gnt_pf) begin
        r_brc_addr <= i_pf_addr;
        r_brc_sel  <= SEL_PF;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpu_busy <= 1'b0;
      r_cpu_wack <= 1'b0;
      r_age_cpu  <= '0;
      r_age_dma  <= '0;
      r_age_pf   <= '0;
      r_tag_vld  <= '0;
      r_tag_sel  <= '0;
    end else begin
      r_age_cpu  <= next_age(w_elig_cpu, w_gnt_cpu, r_age_cpu);
      r_age_dma  <= next_age(w_elig_dma, w_gnt_dma, r_age_dma);
      r_age_pf   <= next_age(w_elig_pf, w_gnt_pf, r_age_pf);
      r_cpu_wack <= r_brc_in_valid & r_brc_wr & (r_brc_sel == SEL_CPU);
      r_tag_vld  <= {r_tag_vld[RD_LATENCY-2:0], w_issue_rd};
      r_tag_sel  <= {r_tag_sel[RD_LATENCY-2:0], r_brc_sel};
      // Busy drops only after the ack cycle, so a held strobe is not regranted during the ack.
      if (w_gnt_cpu)      r_cpu_busy <= 1'b1;
      else if (o_cpu_ack) r_cpu_busy <= 1'b0;
    end
  end

  assign w_issue_rd = r_brc_in_valid & ~r_brc_wr;
  assign w_ret_vld  = r_tag_vld[RD_LATENCY-1];
  assign w_ret_sel  = r_tag_sel[RD_LATENCY-1];

  assign o_dma_gnt        = w_gnt_dma;
  assign o_pf_gnt         = w_gnt_pf;
  assign o_brc_in_valid   = r_brc_in_valid;
  assign o_brc_wr         = r_brc_wr;
  assign o_brc_addr       = r_brc_addr;
  assign o_brc_di         = r_brc_di;
  assign o_brc_reader_sel = r_brc_sel;

  assign o_cpu_ack    = r_cpu_wack | (w_ret_vld & (w_ret_sel == SEL_CPU));
  assign o_cpu_rdata  = (w_ret_vld && w_ret_sel == SEL_CPU) ? i_brc_do : '0;
  assign o_dma_rvalid = w_ret_vld & (w_ret_sel == SEL_DMA);
  assign o_dma_rdata  = o_dma_rvalid ? i_brc_do : '0;
  assign o_pf_rvalid  = w_ret_vld & (w_ret_sel == SEL_PF);
  assign o_pf_rdata   = o_pf_rvalid ? i_brc_do : '0;
endmodule

// File: tb/tb_bram_access_arbiter.sv
// Bench for bram_access_arbiter: acts as the BRAM controller and checks every output each cycle
// against an event-scheduled model of the arbitration, issue and return rules.
module tb_bram_access_arbiter;
  localparam int L   = 10;
  localparam int LIM = 8;
  localparam logic [1:0] S_DMA = 2'b00;
  localparam logic [1:0] S_CPU = 2'b01;
  localparam logic [1:0] S_PF  = 2'b10;

  typedef struct packed {
    logic        dma_gnt;
    logic        pf_gnt;
    logic        brc_in_valid;
    logic        brc_wr;
    logic [12:0] brc_addr;
    logic [31:0] brc_di;
    logic [1:0]  brc_sel;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        pf_rvalid;
    logic [31:0] pf_rdata;
  } out_t;

  typedef struct packed {
    logic        wr;
    logic [12:0] addr;
    logic [31:0] di;
    logic [1:0]  sel;
  } issue_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cpu_stb, cpu_we, dma_req, dma_we, pf_req;
  logic [12:0] cpu_addr, dma_addr, pf_addr;
  logic [31:0] cpu_wdata, dma_wdata, brc_do;
  logic        cpu_ack, dma_gnt, dma_rvalid, pf_gnt, pf_rvalid, brc_in_valid, brc_wr;
  logic [31:0] cpu_rdata, dma_rdata, pf_rdata, brc_di;
  logic [12:0] brc_addr;
  logic [1:0]  brc_reader_sel;

  bram_access_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_stb(cpu_stb), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
    .i_pf_req(pf_req), .i_pf_addr(pf_addr),
    .o_pf_gnt(pf_gnt), .o_pf_rvalid(pf_rvalid), .o_pf_rdata(pf_rdata),
    .o_brc_in_valid(brc_in_valid), .o_brc_wr(brc_wr), .o_brc_addr(brc_addr), .o_brc_di(brc_di),
    .o_brc_reader_sel(brc_reader_sel), .i_brc_do(brc_do)
  );

  int   n_vec = 0;
  int   n_err = 0;
  out_t got, want;

  // Reference state: ages and busy flag, plus cycle-keyed events for issues and returns.
  int          cyc = 0;
  int          age[3];
  bit          busy;
  issue_t      iss_q[int];
  logic [31:0] rd_due[int];
  logic [31:0] cpu_rd[int];
  logic [31:0] dma_rd[int];
  logic [31:0] pf_rd[int];
  bit          cpu_wk[int];
  logic [31:0] mem[int];

  function automatic logic [31:0] mem_rd(input logic [12:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : {16'hC0DE, 3'b000, a};
  endfunction

  // One clock: predict outputs from current inputs, sample the DUT at negedge, advance the model.
  task automatic tick();
    bit          el[3];
    int          win;
    bit          has_iss;
    issue_t      cur;
    logic [31:0] d;
    want    = '0;
    has_iss = iss_q.exists(cyc);
    cur     = has_iss ? iss_q[cyc] : '0;
    if (has_iss) begin
      want.brc_in_valid = 1'b1;
      want.brc_wr       = cur.wr;
      want.brc_addr     = cur.addr;
      want.brc_di       = cur.di;
      want.brc_sel      = cur.sel;
    end
    brc_do = rd_due.exists(cyc) ? rd_due[cyc] : $urandom;
    if (cpu_rd.exists(cyc)) begin want.cpu_ack = 1'b1; want.cpu_rdata = cpu_rd[cyc]; end
    if (cpu_wk.exists(cyc)) want.cpu_ack = 1'b1;
    if (dma_rd.exists(cyc)) begin want.dma_rvalid = 1'b1; want.dma_rdata = dma_rd[cyc]; end
    if (pf_rd.exists(cyc)) begin want.pf_rvalid = 1'b1; want.pf_rdata = pf_rd[cyc]; end
    el[0] = !rst && cpu_stb && !busy;
    el[1] = !rst && dma_req;
    el[2] = !rst && pf_req;
    win = -1;
    for (int p = 0; p < 3; p++) if (win < 0 && el[p] && age[p] == LIM) win = p;
    for (int p = 0; p < 3; p++) if (win < 0 && el[p]) win = p;
    want.dma_gnt = (win == 1);
    want.pf_gnt  = (win == 2);
    @(negedge clk);
    got.dma_gnt      = dma_gnt;
    got.pf_gnt       = pf_gnt;
    got.brc_in_valid = brc_in_valid;
    got.brc_wr       = brc_wr;
    got.brc_addr     = brc_addr;
    got.brc_di       = brc_di;
    got.brc_sel      = brc_reader_sel;
    got.cpu_ack      = cpu_ack;
    got.cpu_rdata    = cpu_rdata;
    got.dma_rvalid   = dma_rvalid;
    got.dma_rdata    = dma_rdata;
    got.pf_rvalid    = pf_rvalid;
    got.pf_rdata     = pf_rdata;
    @(posedge clk);
    if (has_iss && cur.wr) mem[int'(cur.addr)] = cur.di;
    if (rst) begin
      for (int p = 0; p < 3; p++) age[p] = 0;
      busy = 0;
      iss_q.delete(); rd_due.delete(); cpu_rd.delete(); dma_rd.delete(); pf_rd.delete(); cpu_wk.delete();
    end else begin
      for (int p = 0; p < 3; p++)
        age[p] = (el[p] && win != p) ? ((age[p] < LIM) ? age[p] + 1 : LIM) : 0;
      if (want.cpu_ack) busy = 0;
      if (win == 0) busy = 1;
      if (win == 0) iss_q[cyc+1] = '{cpu_we, cpu_addr, cpu_wdata, S_CPU};
      if (win == 1) iss_q[cyc+1] = '{dma_we, dma_addr, dma_wdata, S_DMA};
      if (win == 2) iss_q[cyc+1] = '{1'b0, pf_addr, 32'h0, S_PF};
      if (has_iss && cur.wr && cur.sel == S_CPU) cpu_wk[cyc+1] = 1'b1;
      if (has_iss && !cur.wr) begin
        d = mem_rd(cur.addr);
        rd_due[cyc+L] = d;
        case (cur.sel)
          S_CPU:   cpu_rd[cyc+L] = d;
          S_DMA:   dma_rd[cyc+L] = d;
          default: pf_rd[cyc+L]  = d;
        endcase
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    cpu_stb = 1'b0; dma_req = 1'b0; pf_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_stb = 1'b1; dma_req = 1'b1; pf_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc-1, got, want); end
      n_vec++;
      if (got !== '0) begin n_err++; $display("FAIL reset_zero cyc=%0d got=%h want=0", cyc-1, got); end
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    n_vec++;
    if (got !== '0) begin n_err++; $display("FAIL reset_idle got=%h want=0", got); end
  endtask

  task automatic test_cpu_read();
    int g, iss_c, ack_c, n_iss;
    logic [1:0] sel_at;
    g = cyc; iss_c = -1; ack_c = -1; n_iss = 0; sel_at = 2'b11;
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010; cpu_wdata = $urandom;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL cpu_read_cycle cyc=%0d got=%h want=%h", cyc-1, got, want); end
      if (got.brc_in_valid) begin
        n_iss++;
        if (iss_c < 0) begin iss_c = cyc - 1; sel_at = got.brc_sel; end
      end
      if (got.cpu_ack && ack_c < 0) begin ack_c = cyc - 1; cpu_stb = 1'b0; end
    end
    n_vec++;
    if (iss_c !== g + 1) begin n_err++; $display("FAIL cpu_read_issue got=%0d want=%0d", iss_c - g, 1); end
    n_vec++;
    if (sel_at !== S_CPU) begin n_err++; $display("FAIL cpu_read_sel got=%b want=%b", sel_at, S_CPU); end
    n_vec++;
    if (ack_c !== g + 1 + L) begin n_err++; $display("FAIL cpu_read_ack got=%0d want=%0d", ack_c - g, 1 + L); end
    n_vec++;
    if (n_iss !== 1) begin n_err++; $display("FAIL cpu_busy_regrant issues=%0d want=1", n_iss); end
  endtask

  task automatic test_write_then_read();
    int g, ack_c;
    bit seen;
    logic [31:0] rd;
    g = cyc; ack_c = -1; seen = 0; rd = '0;
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h020; cpu_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL cpu_write_cycle cyc=%0d got=%h want=%h", cyc-1, got, want); end
      if (got.cpu_ack && ack_c < 0) begin ack_c = cyc - 1; cpu_stb = 1'b0; end
    end
    n_vec++;
    if (ack_c !== g + 2) begin n_err++; $display("FAIL cpu_write_ack got=%0d want=2", ack_c - g); end
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h020; dma_wdata = $urandom;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL dma_raw_cycle cyc=%0d got=%h want=%h", cyc-1, got, want); end
      if (got.dma_gnt) dma_req = 1'b0;
      if (got.dma_rvalid) begin seen = 1; rd = got.dma_rdata; end
    end
    n_vec++;
    if (!seen || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL dma_raw_data got=%h seen=%0d want=deadbeef", rd, seen); end
  endtask

  task automatic test_starvation();
    int first_pf, n_pf, n_dma;
    first_pf = -1; n_pf = 0; n_dma = 0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'($urandom_range(8191));
    pf_req = 1'b1; pf_addr = 13'($urandom_range(8191));
    for (int i = 0; i < 30; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL starve_cycle cyc=%0d got=%h want=%h", cyc-1, got, want); end
      n_vec++;
      if ((got.dma_gnt ^ got.pf_gnt) !== 1'b1) begin
        n_err++; $display("FAIL starve_one_grant i=%0d dma=%b pf=%b want exactly one", i, got.dma_gnt, got.pf_gnt);
      end
      if (got.dma_gnt) begin n_dma++; dma_addr = 13'($urandom_range(8191)); end
      if (got.pf_gnt) begin
        n_pf++; pf_addr = 13'($urandom_range(8191));
        if (first_pf < 0) first_pf = i;
      end
    end
    n_vec++;
    if (first_pf !== LIM) begin n_err++; $display("FAIL starve_first_pf got=%0d want=%0d", first_pf, LIM); end
    n_vec++;
    if (n_pf !== 3 || n_dma !== 27) begin n_err++; $display("FAIL starve_split pf=%0d dma=%0d want 3/27", n_pf, n_dma); end
    idle_inputs();
    for (int i = 0; i < L + 2; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL starve_drain cyc=%0d got=%h want=%h", cyc-1, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    int n_iss, f_iss, l_iss, n_rv, f_rv, l_rv;
    logic [12:0] a;
    n_iss = 0; f_iss = -1; l_iss = -1; n_rv = 0; f_rv = -1; l_rv = -1;
    a = 13'd0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = a;
    for (int i = 0; i < 8 + L + 4; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL b2b_cycle cyc=%0d got=%h want=%h", cyc-1, got, want); end
      if (got.brc_in_valid) begin n_iss++; if (f_iss < 0) f_iss = i; l_iss = i; end
      if (got.dma_rvalid) begin
        a = 13'(n_rv);
        n_vec++;
        if (got.dma_rdata !== {16'hC0DE, 3'b000, a}) begin
          n_err++; $display("FAIL b2b_data k=%0d got=%h want=%h", n_rv, got.dma_rdata, {16'hC0DE, 3'b000, a});
        end
        n_rv++; if (f_rv < 0) f_rv = i; l_rv = i;
      end
      if (got.dma_gnt) begin
        if (dma_addr == 13'd7) dma_req = 1'b0;
        else dma_addr = dma_addr + 13'd1;
      end
    end
    n_vec++;
    if (n_iss !== 8 || l_iss - f_iss !== 7) begin n_err++; $display("FAIL b2b_issues n=%0d span=%0d want 8/7", n_iss, l_iss - f_iss); end
    n_vec++;
    if (n_rv !== 8 || l_rv - f_rv !== 7) begin n_err++; $display("FAIL b2b_rvalid n=%0d span=%0d want 8/7", n_rv, l_rv - f_rv); end
    n_vec++;
    if (f_rv - f_iss !== L) begin n_err++; $display("FAIL b2b_latency got=%0d want=%0d", f_rv - f_iss, L); end
  endtask

  task automatic test_all_three();
    logic [1:0] sels[$];
    int first_pf;
    first_pf = -1;
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 13'($urandom_range(8191));
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'($urandom_range(8191));
    pf_req = 1'b1; pf_addr = 13'($urandom_range(8191));
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL all3_cycle cyc=%0d got=%h want=%h", cyc-1, got, want); end
      if (got.brc_in_valid) sels.push_back(got.brc_sel);
      if (got.cpu_ack) cpu_stb = 1'b0;
      if (got.dma_gnt) dma_addr = 13'($urandom_range(8191));
      if (got.pf_gnt && first_pf < 0) begin first_pf = i; pf_req = 1'b0; end
    end
    n_vec++;
    if (sels.size() < 2 || sels[0] !== S_CPU || sels[1] !== S_DMA) begin
      n_err++; $display("FAIL all3_order n=%0d first=%b second=%b want 01 then 00", sels.size(),
                        (sels.size() > 0) ? sels[0] : 2'b11, (sels.size() > 1) ? sels[1] : 2'b11);
    end
    n_vec++;
    if (first_pf !== LIM) begin n_err++; $display("FAIL all3_pf_urgent got=%0d want=%0d", first_pf, LIM); end
    idle_inputs();
    for (int i = 0; i < L + 2; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL all3_drain cyc=%0d got=%h want=%h", cyc-1, got, want); end
    end
  endtask

  task automatic test_reset_midflight();
    int n_resp;
    bit seen;
    logic [31:0] rd;
    n_resp = 0; seen = 0; rd = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h100;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) dma_req = 1'b0;
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL rstmid_pre cyc=%0d got=%h want=%h", cyc-1, got, want); end
      if (got.dma_gnt) dma_addr = dma_addr + 13'd1;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < L + 4; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL rstmid_post cyc=%0d got=%h want=%h", cyc-1, got, want); end
      if (i == 0) begin
        n_vec++;
        if (got !== '0) begin n_err++; $display("FAIL rstmid_zero got=%h want=0", got); end
      end
      if (got.dma_rvalid || got.pf_rvalid || got.cpu_ack) n_resp++;
    end
    n_vec++;
    if (n_resp !== 0) begin n_err++; $display("FAIL rstmid_stale responses=%0d want=0", n_resp); end
    dma_req = 1'b1; dma_addr = 13'd5;
    for (int i = 0; i < L + 4; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL rstmid_after cyc=%0d got=%h want=%h", cyc-1, got, want); end
      if (got.dma_gnt) dma_req = 1'b0;
      if (got.dma_rvalid) begin seen = 1; rd = got.dma_rdata; end
    end
    n_vec++;
    if (!seen || rd !== 32'hC0DE0005) begin n_err++; $display("FAIL rstmid_resume got=%h seen=%0d want=c0de0005", rd, seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL random_cycle cyc=%0d got=%h want=%h", cyc-1, got, want); end
      if (rst) rst = 1'b0;
      else begin
        if (got.cpu_ack) cpu_stb = 1'b0;
        if (got.dma_gnt) dma_req = 1'b0;
        if (got.pf_gnt) pf_req = 1'b0;
        if ($urandom_range(149) == 0) begin
          rst = 1'b1;
          idle_inputs();
        end else begin
          if (!cpu_stb && $urandom_range(3) == 0) begin
            cpu_stb = 1'b1; cpu_we = 1'($urandom_range(1));
            cpu_addr = 13'($urandom_range(31)); cpu_wdata = $urandom;
          end
          if (!dma_req && $urandom_range(2) == 0) begin
            dma_req = 1'b1; dma_we = 1'($urandom_range(1));
            dma_addr = 13'($urandom_range(31)); dma_wdata = $urandom;
          end
          if (!pf_req && $urandom_range(2) == 0) begin
            pf_req = 1'b1; pf_addr = 13'($urandom_range(31));
          end
        end
      end
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < L + 3; i++) begin
      tick();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc-1, got, want); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    pf_req = 1'b0; pf_addr = '0; brc_do = '0;
    for (int p = 0; p < 3; p++) age[p] = 0;
    busy = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_cpu_read();
    test_write_then_read();
    test_starvation();
    test_back_to_back();
    test_all_three();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
